shift_arbiter: RTL

Shares a single 32-bit barrel shifter (SLL/SRL/SRA) between two requesters, for example the execute stage and the load/store byte-alignment path. Each requester has a valid/ready handshake. Arbitration is round-robin. The result is registered in a one-entry output buffer with its own valid/ready handshake, and is tagged with the source requester and a caller-supplied tag. The block sits beside the ALU in the execute stage.

---
 rtl/shift_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one 32-bit barrel shifter (SLL/SRL/SRA) through a one-entry output buffer.
// Define SHIFT_ARB_FIXED_PRIO_EN for fixed priority to requester 0; the default build is round-robin.
module shift_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [31:0]      r0_data,
  input  logic [4:0]       r0_shamt,
  input  logic [1:0]       r0_op,
  input  logic [TAG_W-1:0] r0_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [31:0]      r1_data,
  input  logic [4:0]       r1_shamt,
  input  logic [1:0]       r1_op,
  input  logic [TAG_W-1:0] r1_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_src,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  logic [0:0]       state_q, state_d;
  logic [31:0]      data_q, data_d;
  logic             src_q, src_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;

  logic             can_accept;
  logic             grant;
  logic             accept;
  logic [31:0]      sel_data;
  logic [4:0]       sel_shamt;
  logic [1:0]       sel_op;
  logic [TAG_W-1:0] sel_tag;
  logic [31:0]      shift_res;
  logic             shift_err;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = !r0_valid && r1_valid;
  end
`else
  logic rr_last_q, rr_last_d;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    if (r0_valid && r1_valid) begin
      grant = ~rr_last_q;
    end else begin
      grant = r1_valid;
    end
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (accept) begin
      rr_last_d = grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`endif

  assign can_accept = (state_q == ST_EMPTY) || out_ready;
  assign r0_ready   = can_accept && !grant && !rst;
  assign r1_ready   = can_accept && grant && !rst;
  assign accept     = grant ? (r1_valid && r1_ready) : (r0_valid && r0_ready);

  assign sel_data  = grant ? r1_data  : r0_data;
  assign sel_shamt = grant ? r1_shamt : r0_shamt;
  assign sel_op    = grant ? r1_op    : r0_op;
  assign sel_tag   = grant ? r1_tag   : r0_tag;

  always_comb begin
    shift_res = '0;
    shift_err = 1'b0;
    case (sel_op)
      OP_SLL:  shift_res = sel_data << sel_shamt;
      OP_SRL:  shift_res = sel_data >> sel_shamt;
      OP_SRA:  shift_res = $unsigned($signed(sel_data) >>> sel_shamt);
      default: shift_err = 1'b1;
    endcase
  end

  // A drain and a fill on the same edge leave the buffer full with the new result.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    tag_d   = tag_q;
    err_d   = err_q;
    if (accept) begin
      state_d = ST_FULL;
      data_d  = shift_res;
      src_d   = grant;
      tag_d   = sel_tag;
      err_d   = shift_err;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= 1'b0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_tag   = tag_q;
  assign out_err   = err_q;

endmodule
